// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (IFU read-only, LSU read/write) arbiter and
// sequencer for a single-port memory. Each access runs IDLE -> ACCESS ->
// CAPTURE -> RESP; the memory's one-cycle-late read data is held for the owner.
// Build option: MEM_ARB_FIXED_PRIO_EN selects fixed LSU-over-IFU priority;
// when undefined, arbitration is round-robin.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_req_addr,
  output logic                ifu_resp_valid,
  input  logic                ifu_resp_ready,
  output logic [DATA_W-1:0]   ifu_resp_data,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic                lsu_req_wen,
  input  logic [ADDR_W-1:0]   lsu_req_addr,
  input  logic [DATA_W-1:0]   lsu_req_wdata,
  input  logic [DATA_W/8-1:0] lsu_req_wmask,
  output logic                lsu_resp_valid,
  input  logic                lsu_resp_ready,
  output logic [DATA_W-1:0]   lsu_resp_data,
  output logic                mem_valid,
  output logic                mem_wen,
  output logic [ADDR_W-1:0]   mem_raddr,
  output logic [ADDR_W-1:0]   mem_waddr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int unsigned MASK_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;   // 0 = IFU, 1 = LSU
  logic                wen_q, wen_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [MASK_W-1:0]   wmask_q, wmask_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                grant_ifu, grant_lsu;

`ifdef MEM_ARB_FIXED_PRIO_EN
  // Fixed priority: LSU always beats IFU.
  always_comb begin
    grant_lsu = lsu_req_valid;
    grant_ifu = ifu_req_valid && !lsu_req_valid;
  end
`else
  logic ptr_q, ptr_d;  // 0 favours IFU, 1 favours LSU

  // Round-robin grant: a lone requester wins, the pointer breaks ties.
  always_comb begin
    grant_lsu = lsu_req_valid && (!ifu_req_valid || ptr_q);
    grant_ifu = ifu_req_valid && (!lsu_req_valid || !ptr_q);
  end

  // Pointer moves to the requester that was not just granted.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == IDLE) begin
      if (grant_ifu)      ptr_d = 1'b1;
      else if (grant_lsu) ptr_d = 1'b0;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end
`endif

  // Next-state, request latching and handshake outputs.
  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    wen_d          = wen_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    wmask_d        = wmask_q;
    rdata_d        = rdata_q;
    ifu_req_ready  = 1'b0;
    lsu_req_ready  = 1'b0;
    ifu_resp_valid = 1'b0;
    lsu_resp_valid = 1'b0;
    mem_valid      = 1'b0;
    unique case (state_q)
      IDLE: begin
        ifu_req_ready = grant_ifu;
        lsu_req_ready = grant_lsu;
        if (grant_lsu) begin
          owner_d = 1'b1;
          wen_d   = lsu_req_wen;
          addr_d  = lsu_req_addr;
          wdata_d = lsu_req_wdata;
          wmask_d = lsu_req_wmask;
          state_d = ACCESS;
        end else if (grant_ifu) begin
          owner_d = 1'b0;
          wen_d   = 1'b0;
          addr_d  = ifu_req_addr;
          wdata_d = '0;
          wmask_d = '0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        mem_valid = 1'b1;
        state_d   = CAPTURE;
      end
      CAPTURE: begin
        rdata_d = wen_q ? '0 : mem_rdata;
        state_d = RESP;
      end
      RESP: begin
        ifu_resp_valid = !owner_q;
        lsu_resp_valid = owner_q;
        if (owner_q ? lsu_resp_ready : ifu_resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      rdata_q <= rdata_d;
    end
  end

  assign mem_wen       = (state_q == ACCESS) && wen_q;
  assign mem_raddr     = addr_q;
  assign mem_waddr     = addr_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;
  assign ifu_resp_data = rdata_q;
  assign lsu_resp_data = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: table of single transactions plus
// hand-written sequences for arbitration, back-pressure and mid-access reset.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready;
  logic [31:0] ifu_req_addr;
  logic [63:0] ifu_resp_data;
  logic        lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_resp_valid, lsu_resp_ready;
  logic [31:0] lsu_req_addr;
  logic [63:0] lsu_req_wdata, lsu_resp_data;
  logic [7:0]  lsu_req_wmask;
  logic        mem_valid, mem_wen;
  logic [31:0] mem_raddr, mem_waddr;
  logic [63:0] mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;
  logic [63:0] mem_val;

  int checks = 0;
  int failures = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_req_addr(ifu_req_addr), .ifu_resp_valid(ifu_resp_valid),
    .ifu_resp_ready(ifu_resp_ready), .ifu_resp_data(ifu_resp_data),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
    .lsu_req_wen(lsu_req_wen), .lsu_req_addr(lsu_req_addr),
    .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready),
    .lsu_resp_data(lsu_resp_data),
    .mem_valid(mem_valid), .mem_wen(mem_wen),
    .mem_raddr(mem_raddr), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: read data appears only in the cycle after the strobe.
  always @(posedge clk) mem_rdata <= mem_valid ? mem_val : 64'h0;

  typedef struct {
    bit          lsu;
    bit          wen;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic [63:0] rdata;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction from IDLE with resp_ready tied high.
  task automatic do_txn(input vec_t v);
    mem_val = v.rdata;
    ifu_resp_ready = 1'b1;
    lsu_resp_ready = 1'b1;
    if (v.lsu) begin
      lsu_req_valid = 1'b1;
      lsu_req_wen   = v.wen;
      lsu_req_addr  = v.addr;
      lsu_req_wdata = v.wdata;
      lsu_req_wmask = v.wmask;
    end else begin
      ifu_req_valid = 1'b1;
      ifu_req_addr  = v.addr;
    end
    #1;
    chk("own_req_ready", v.lsu ? lsu_req_ready : ifu_req_ready, 1);
    chk("other_req_ready", v.lsu ? ifu_req_ready : lsu_req_ready, 0);
    tick();
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    chk("access_mem_valid", mem_valid, 1);
    chk("access_mem_wen", mem_wen, v.wen);
    chk("access_raddr", mem_raddr, v.addr);
    chk("access_waddr", mem_waddr, v.addr);
    if (v.wen) begin
      chk("access_wdata", mem_wdata, v.wdata);
      chk("access_wmask", mem_wmask, v.wmask);
    end
    tick();
    chk("capture_mem_valid", mem_valid, 0);
    chk("capture_mem_wen", mem_wen, 0);
    tick();
    chk("resp_valid_own", v.lsu ? lsu_resp_valid : ifu_resp_valid, 1);
    chk("resp_valid_other", v.lsu ? ifu_resp_valid : lsu_resp_valid, 0);
    chk("resp_data", v.lsu ? lsu_resp_data : ifu_resp_data, v.exp);
    tick();
    chk("resp_valid_drop", v.lsu ? lsu_resp_valid : ifu_resp_valid, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    logic exp_g [4];
    logic found;
    vec_t v;

    vecs[0] = '{lsu: 0, wen: 0, addr: 32'h10, wdata: 64'h0, wmask: 8'h00,
                rdata: 64'h1122334455667788, exp: 64'h1122334455667788};
    vecs[1] = '{lsu: 1, wen: 1, addr: 32'h20, wdata: 64'hAB, wmask: 8'h01,
                rdata: 64'hFFFF0000FFFF0000, exp: 64'h0};
    vecs[2] = '{lsu: 1, wen: 0, addr: 32'h33, wdata: 64'h5555, wmask: 8'hFF,
                rdata: 64'h0123456789ABCDEF, exp: 64'h0123456789ABCDEF};
    vecs[3] = '{lsu: 1, wen: 1, addr: 32'hFFFFFFFD, wdata: 64'hDEADBEEFCAFEF00D, wmask: 8'hF0,
                rdata: 64'h1, exp: 64'h0};
    vecs[4] = '{lsu: 0, wen: 0, addr: 32'h80000004, wdata: 64'h0, wmask: 8'h00,
                rdata: 64'hFFFFFFFFFFFFFFFF, exp: 64'hFFFFFFFFFFFFFFFF};

`ifdef MEM_ARB_FIXED_PRIO_EN
    exp_g = '{1'b1, 1'b1, 1'b1, 1'b1};
`else
    exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif

    ifu_req_valid = 0; ifu_req_addr = '0; ifu_resp_ready = 0;
    lsu_req_valid = 0; lsu_req_wen = 0; lsu_req_addr = '0;
    lsu_req_wdata = '0; lsu_req_wmask = '0; lsu_resp_ready = 0;
    mem_val = '0;

    // Reset state: all outputs idle, no strobe while nothing requests.
    rst_n = 1'b0;
    #12;
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_ifu_req_ready", ifu_req_ready, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("idle_mem_valid", mem_valid, 0);
    end
    chk("rst_lsu_req_ready", lsu_req_ready, 0);
    chk("rst_ifu_resp_valid", ifu_resp_valid, 0);
    chk("rst_lsu_resp_valid", lsu_resp_valid, 0);
    chk("rst_mem_wen", mem_wen, 0);
    chk("rst_mem_raddr", mem_raddr, 0);
    chk("rst_mem_waddr", mem_waddr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_wmask", mem_wmask, 0);
    chk("rst_ifu_resp_data", ifu_resp_data, 0);
    chk("rst_lsu_resp_data", lsu_resp_data, 0);

    // Table of single transactions.
    for (int i = 0; i < 5; i++) do_txn(vecs[i]);

    // Both requesters valid every cycle: grant order.
    do_reset();
    ifu_resp_ready = 1; lsu_resp_ready = 1;
    ifu_req_valid = 1; ifu_req_addr = 32'h100;
    lsu_req_valid = 1; lsu_req_wen = 0; lsu_req_addr = 32'h200;
    mem_val = 64'h77;
    #1;
    for (int g = 0; g < 4; g++) begin
      found = 0;
      for (int c = 0; c < 10 && !found; c++) begin
        if (ifu_req_ready || lsu_req_ready) begin
          found = 1;
          chk("grant_seq", lsu_req_ready, exp_g[g]);
          chk("grant_onehot", ifu_req_ready & lsu_req_ready, 0);
        end
        tick();
      end
      if (!found) chk("grant_timeout", 0, 1);
    end
    ifu_req_valid = 0; lsu_req_valid = 0;
    repeat (4) tick();

    // LSU read held in RESP by back-pressure while IFU waits.
    mem_val = 64'hCAFEF00DDEADBEEF;
    lsu_resp_ready = 0; ifu_resp_ready = 1;
    lsu_req_valid = 1; lsu_req_wen = 0; lsu_req_addr = 32'h40;
    #1;
    chk("hold_lsu_accept", lsu_req_ready, 1);
    tick();
    lsu_req_valid = 0;
    ifu_req_valid = 1; ifu_req_addr = 32'h50;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("hold_lsu_resp_valid", lsu_resp_valid, 1);
      chk("hold_lsu_resp_data", lsu_resp_data, 64'hCAFEF00DDEADBEEF);
      chk("hold_ifu_req_ready", ifu_req_ready, 0);
      chk("hold_mem_valid", mem_valid, 0);
      tick();
    end
    lsu_resp_ready = 1;
    mem_val = 64'h0A0B0C0D01020304;
    tick();
    chk("hold_release_resp_valid", lsu_resp_valid, 0);
    chk("hold_release_ifu_ready", ifu_req_ready, 1);
    tick();
    ifu_req_valid = 0;
    chk("hold_ifu_raddr", mem_raddr, 32'h50);
    tick();
    tick();
    chk("hold_ifu_resp_valid", ifu_resp_valid, 1);
    chk("hold_ifu_resp_data", ifu_resp_data, 64'h0A0B0C0D01020304);
    tick();

    // Reset pulse during CAPTURE discards the pending response.
    mem_val = 64'h9999;
    ifu_req_valid = 1; ifu_req_addr = 32'h60;
    #1;
    chk("rstcap_accept", ifu_req_ready, 1);
    tick();
    ifu_req_valid = 0;
    tick();
    rst_n = 0;
    #1;
    chk("rstcap_raddr", mem_raddr, 0);
    chk("rstcap_mem_valid", mem_valid, 0);
    #2;
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rstcap_no_resp", ifu_resp_valid, 0);
      chk("rstcap_no_strobe", mem_valid, 0);
    end
    v = '{lsu: 0, wen: 0, addr: 32'h70, wdata: 64'h0, wmask: 8'h00,
          rdata: 64'h5A5A5A5AA5A5A5A5, exp: 64'h5A5A5A5AA5A5A5A5};
    do_txn(v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and sequencer for the single-port simulation memory in the NPC. Shares the memory port between the instruction fetch unit (read-only) and the load/store unit (read/write), serialises accesses through a four-state FSM, and captures the memory's one-cycle-late, self-clearing read data into a held response with valid/ready handshakes on both sides.

## Interface
- ADDR_W, 32, address width on all ports
- DATA_W, 64, data width; mask width is DATA_W/8
- clk  in  1  clock, all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- ifu_req_valid  in  1  IFU read request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_req_addr  in  ADDR_W  IFU read address
- ifu_resp_valid  out  1  IFU response held
- ifu_resp_ready  in  1  IFU consumes response
- ifu_resp_data  out  DATA_W  IFU read data
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_req_wen  in  1  1 = write, 0 = read
- lsu_req_addr  in  ADDR_W  LSU address
- lsu_req_wdata  in  DATA_W  write data
- lsu_req_wmask  in  DATA_W/8  byte write mask
- lsu_resp_valid  out  1  LSU response held (read data or write ack)
- lsu_resp_ready  in  1  LSU consumes response
- lsu_resp_data  out  DATA_W  read data; 0 for write ack
- mem_valid  out  1  memory access strobe, one cycle per access
- mem_wen  out  1  memory write enable
- mem_raddr / mem_waddr  out  ADDR_W  both driven with the latched address
- mem_wdata  out  DATA_W  latched write data
- mem_wmask  out  DATA_W/8  latched mask
- mem_rdata  in  DATA_W  memory read data, valid only in the cycle after mem_valid

## Operation
- States: IDLE, ACCESS, CAPTURE, RESP. Reset → IDLE.
- IDLE: grant computed combinationally; only the granted requester sees req_ready=1. Handshake (valid && ready) latches owner, wen (forced 0 for IFU), addr, wdata, wmask → ACCESS. No valid → stay.
- ACCESS: mem_valid=1, mem_wen=latched wen, mem addresses/data/mask from latches, for exactly one cycle → CAPTURE.
- CAPTURE: mem_valid=0; resp_data register loads mem_rdata for reads, 0 for writes → RESP.
- RESP: owner's resp_valid=1, resp_data stable; other requester's resp_valid=0. Leave to IDLE on the edge where owner's resp_ready=1.
- Arbitration (default): round-robin; priority pointer moves to the non-granted requester after each grant. Single requester always wins regardless of pointer.
- Requesters must hold valid and payload stable until ready; inputs are not sampled outside IDLE.
- Address and mask passed unmodified; no alignment check.

## Timing
- Reset values: all req_ready, resp_valid, mem_valid, mem_wen = 0; all data/address/mask outputs = 0; pointer favours IFU.
- Accept at edge E0 → mem_valid high in cycle after E0 → data captured at E2 → resp_valid high from cycle after E2. Minimum request-to-next-accept: 4 cycles (resp_ready tied high).
- resp_ready held low: RESP persists indefinitely, data unchanged, no new accepts.
- Simultaneous IFU and LSU valid in IDLE: pointer decides; loser's ready=0, served on the next IDLE.
- rst_n asserted mid-operation: immediate return to IDLE with reset values; pending response discarded; a write already strobed in ACCESS is not undone.

## Configuration
- MEM_ARB_FIXED_PRIO_EN defined: fixed priority, LSU always wins over IFU; pointer logic removed.
- Undefined: round-robin as above.

## Test plan
- Reset: rst_n=0 then released, no requests → all outputs 0, req_ready=0 for both, mem_valid never asserts.
- IFU read addr 0x10, mem_rdata=0x1122334455667788 in cycle after mem_valid → mem_valid one cycle with wen=0, raddr=0x10; ifu_resp_data=0x1122334455667788 three cycles after accept.
- LSU write addr 0x20, wdata=0xAB, wmask=0x01 → mem_wen=1, waddr=0x20, wdata=0xAB, wmask=0x01 for one cycle; lsu_resp_valid with data 0.
- Both valid every cycle, resp_ready=1 → grants alternate IFU, LSU, IFU, LSU; with MEM_ARB_FIXED_PRIO_EN only LSU granted.
- LSU read, lsu_resp_ready low 5 cycles → lsu_resp_valid and data held 5 cycles, ifu_req_ready stays 0, then IDLE after ready.
- rst_n pulsed low during CAPTURE → no resp_valid afterwards, FSM in IDLE, next request serviced normally.
